// File: rtl/ysyx_24100027_ifu_if.sv
// Instruction-fetch memory bus.
// Carries one fetch request channel (valid/addr/ready) and one response
// channel (valid/data/err).
//   master : the fetch unit. It drives the request and receives the response.
//   slave  : the memory. It accepts the request and drives the response.
interface ysyx_24100027_ifu_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  mem_rsp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output mem_rsp_err
    );
endinterface

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit.
// Fetches one instruction at a time from memory and presents it to the CPU
// together with its address. The unit cycles through three states:
//   REQ  - issue a request
//   WAIT - wait for the response
//   HOLD - hand the instruction to the CPU
// A memory error, or a misaligned redirect target, parks the unit in FAULT.
// It leaves FAULT only when the CPU supplies an aligned redirect.
// Ports:
//   clk            - clock; all state changes on the rising edge
//   rst            - asynchronous active-low reset
//   mem            - fetch bus (master side)
//   pc, inst       - address and word of the instruction held for the CPU
//   inst_valid     - pc/inst are valid (HOLD only)
//   inst_ready     - CPU consumes pc/inst this cycle
//   redirect_valid - next pc comes from redirect_pc (sampled in HOLD/FAULT)
//   redirect_pc    - redirect target
//   fetch_fault    - sticky fault flag
module ysyx_24100027_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24100027_ifu_if.master        mem,
    output logic [31:0]                pc,
    output logic [31:0]                inst,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       fetch_fault
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_req_valid;
    logic        r_inst_valid;
    logic        r_fault;

    logic [31:0] w_pc_inc;
    logic [31:0] w_next_pc;
    logic        w_next_misaligned;
    logic        w_redir_aligned;

    // The addition wraps naturally, so 32'hFFFF_FFFC + 4 gives 0.
    assign w_pc_inc          = r_pc + 32'd4;
    assign w_next_pc         = redirect_valid ? redirect_pc : w_pc_inc;
    assign w_next_misaligned = (w_next_pc[1:0] != 2'b00);
    assign w_redir_aligned   = (redirect_pc[1:0] == 2'b00);

    // Fetch FSM: holds the state and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // r_req_valid is low here only on the first cycle after
                    // reset. Every other entry into REQ raises it together
                    // with the state change.
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                    end else if (mem.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        if (mem.mem_rsp_err) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_inst       <= mem.mem_rsp_data;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_next_pc;
                        // A misaligned target is loaded into pc so that the
                        // CPU can see which address faulted. No request is
                        // issued for it.
                        if (w_next_misaligned) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_FAULT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                        if (w_redir_aligned) begin
                            r_fault     <= 1'b0;
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state      <= S_REQ;
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_addr  = r_pc;
    assign pc                = r_pc;
    assign inst              = r_inst;
    assign inst_valid        = r_inst_valid;
    assign fetch_fault       = r_fault;

endmodule

// File: doc/ysyx_24100027_ifu.md
YSYX_24100027_IFU -- requirements
Module: ysyx_24100027_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port mem_req_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port mem_rsp_valid  input  1  response valid; arrives no earlier than 1 cycle after request handshake.
REQ-008 SHALL have port mem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port mem_rsp_err  input  1  access error, qualified by mem_rsp_valid.
REQ-010 SHALL have port pc  output  32  address of the instruction on inst, supplied to the CPU.
REQ-011 SHALL have port inst  output  32  instruction word, supplied to the CPU.
REQ-012 SHALL have port inst_valid  output  1  pc/inst valid for the CPU.
REQ-013 SHALL have port inst_ready  input  1  CPU consumes pc/inst this cycle.
REQ-014 SHALL have port redirect_valid  input  1  next pc comes from redirect_pc (branch/jump).
REQ-015 SHALL have port redirect_pc  input  32  redirect target.
REQ-016 SHALL have port fetch_fault  output  1  sticky fault flag.

Function
REQ-017 SHALL implement states REQ, WAIT, HOLD, FAULT.
REQ-018 In REQ: drive mem_req_valid=1 and mem_req_addr=pc; on mem_req_ready=1 go to WAIT; otherwise hold request and address stable.
REQ-019 In WAIT: on mem_rsp_valid with err=0, latch inst<=mem_rsp_data and go to HOLD; with err=1, go to FAULT.
REQ-020 In HOLD: drive inst_valid=1; pc and inst stay stable until inst_ready=1.
REQ-021 In HOLD with inst_ready=1: update pc to redirect_pc if redirect_valid=1, else pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); go to REQ.
REQ-022 A redirect_valid=1 in REQ or WAIT SHALL be ignored; the CPU asserts redirect only alongside inst_ready.
REQ-023 Misaligned target (redirect_pc[1:0]!=0) SHALL load pc with the target and enter FAULT without issuing a request.
REQ-024 In FAULT: fetch_fault=1, inst_valid=0, mem_req_valid=0; leave only on redirect_valid=1 with an aligned target: load pc, clear fetch_fault, go to REQ.
REQ-025 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-026 inst_valid SHALL be 1 only in HOLD; mem_req_valid only in REQ.
REQ-027 With ready=1 everywhere and 1-cycle memory response, throughput SHALL be one instruction per 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-028 While rst=0: state=REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, fetch_fault=0, mem_req_valid=0.
REQ-029 On the first rising edge after rst deasserts: mem_req_valid=1, mem_req_addr=RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL abandon it; a response arriving after reset is ignored (REQ-025).

Verification
REQ-031 Reset release, ready=1, rsp data 32'h00000093 one cycle later -> inst_valid=1, pc=32'h80000000, inst=32'h00000093; next request addr 32'h80000004.
REQ-032 mem_req_ready held low 5 cycles -> mem_req_valid and addr stay stable 5 cycles; no state change.
REQ-033 HOLD, inst_ready=1, redirect_valid=1, redirect_pc=32'h80000100 -> next mem_req_addr=32'h80000100.
REQ-034 inst_ready=0 for 4 cycles in HOLD -> pc/inst unchanged, no new request.
REQ-035 mem_rsp_err=1 -> fetch_fault=1, inst_valid=0; then redirect to 32'h80000000 -> fault cleared, request issued.
REQ-036 Redirect to 32'h80000002 -> FAULT without request; pc=32'h80000002; rst=0 mid-WAIT -> pc=RESET_PC, inst_valid=0.
